// File: rtl/max7219_spi_receiver.sv
// Receive-side model of the MAX7219 3-wire serial link: synchronises sck/din/cs,
// shifts in 16-bit frames and applies them to a MAX7219-style register file.
module max7219_spi_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_din,
  input  logic        spi_cs,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    LATCH     = 2'd3
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic [SYNC_STAGES-1:0] cs_sync;

  logic sck_s;
  logic din_s;
  logic cs_s;
  logic sck_d;
  logic cs_d;

  logic sck_rise;
  logic cs_rise;
  logic cs_fall;

  // The top address nibble of a frame is don't-care, so only the low 12 bits
  // of the serial stream are retained.
  logic [11:0] shreg;
  logic [4:0]  bit_cnt;

  logic [3:0] lat_addr;
  logic [7:0] lat_data;

  // Chains reset to 0 so a frame already in progress at reset release looks
  // like cs held low, which WAIT_HIGH then ignores until cs is seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= '0;
      din_sync <= '0;
      cs_sync  <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      din_sync <= {din_sync[SYNC_STAGES-2:0], spi_din};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  assign lat_addr = shreg[11:8];
  assign lat_data = shreg[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_HIGH;
      shreg        <= '0;
      bit_cnt      <= '0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      case (state)
        WAIT_HIGH: begin
          if (cs_s) state <= IDLE;
        end

        IDLE: begin
          if (cs_fall) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          // A cs rising edge ends the frame even if an sck edge lands with it.
          if (cs_rise) begin
            state <= LATCH;
          end else if (sck_rise) begin
            shreg <= {shreg[10:0], din_s};
            if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
          end
        end

        LATCH: begin
          state <= IDLE;
          if (bit_cnt != 5'd16) begin
            frame_err <= 1'b1;
          end else begin
            frame_valid <= 1'b1;
            frame_addr  <= lat_addr;
            frame_data  <= lat_data;
            case (lat_addr)
              4'h9: decode_mode  <= lat_data;
              4'hA: intensity    <= lat_data[3:0];
              4'hB: scan_limit   <= lat_data[2:0];
              4'hC: shutdown_n   <= lat_data[0];
              4'hF: display_test <= lat_data[0];
              default: begin
                // 0x1-0x8 select a digit; 0x0, 0xD and 0xE write nothing.
                for (int i = 0; i < 8; i++) begin
                  if (lat_addr == 4'(i + 1)) digits[i*8 +: 8] <= lat_data;
                end
              end
            endcase
          end
        end

        default: state <= WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// Bench for max7219_spi_receiver: bit-bangs frames at sck = clk/8 and scores
// every frame_valid / frame_err pulse against an expected queue.
module tb_max7219_spi_receiver;

  localparam int SYNC_STAGES = 2;

  logic        clk;
  logic        rst;
  logic        spi_sck;
  logic        spi_din;
  logic        spi_cs;
  logic [63:0] digits;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic        frame_valid;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_err;

  max7219_spi_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sck      (spi_sck),
    .spi_din      (spi_din),
    .spi_cs       (spi_cs),
    .digits       (digits),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test),
    .frame_valid  (frame_valid),
    .frame_addr   (frame_addr),
    .frame_data   (frame_data),
    .frame_err    (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // {is_err, addr, data}
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  logic [63:0] digits_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      pulse_cnt++;
      check("pulse_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {frame_err, frame_valid}, mon_e[12] ? 64'd2 : 64'd1);
        if (!mon_e[12]) begin
          check("frame_addr", frame_addr, mon_e[11:8]);
          check("frame_data", frame_data, mon_e[7:0]);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Shift nbits of bits (MSB first); rst_at >= 0 pulses reset after that many bits.
  task automatic send_frame(input logic [31:0] bits, input int nbits, input int rst_at);
    int lat;
    bit seen;
    if (rst_at < 0) begin
      if (nbits < 16) exp_q.push_back(13'h1000);
      else exp_q.push_back({1'b0, bits[11:0]});
    end
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_din = bits[i];
      spi_sck = 1'b0;
      if (nbits - 1 - i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
    end
    spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    if (rst_at < 0) begin
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
        @(negedge clk);
        lat++;
        if (frame_valid || frame_err) seen = 1'b1;
      end
      check("latency", lat, SYNC_STAGES + 2);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, digits, 64'd0);
    check({tag, "_ctrl"}, {decode_mode, intensity, scan_limit, shutdown_n, display_test}, 64'd0);
    check({tag, "_frame"}, {frame_valid, frame_err, frame_addr, frame_data}, 64'd0);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    rst = 1'b0;
    spi_sck = 1'b0;
    spi_din = 1'b0;
    spi_cs = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: idle after reset
    check_all_zero("reset");
    repeat (100) @(negedge clk);
    check_all_zero("idle");
    check("idle_pulses", pulse_cnt, 0);

    // 2: shutdown register
    send_frame(32'h0C01, 16, -1);
    check("shutdown_n", shutdown_n, 1);
    check("frames_after_t2", pulse_cnt, 1);

    // 3: digit registers
    send_frame(32'h013D, 16, -1);
    send_frame(32'h024F, 16, -1);
    send_frame(32'h0377, 16, -1);
    send_frame(32'h043D, 16, -1);
    send_frame(32'h051F, 16, -1);
    send_frame(32'h064F, 16, -1);
    send_frame(32'h074F, 16, -1);
    send_frame(32'h0847, 16, -1);
    check("digits_t3", digits, 64'h474F4F1F3D774F3D);

    // random digit writes against a digit model
    digits_m = 64'h474F4F1F3D774F3D;
    for (int k = 0; k < 4; k++) begin
      a = 4'($urandom_range(1, 8));
      d = 8'($urandom_range(0, 255));
      digits_m[(a - 1) * 8 +: 8] = d;
      send_frame({20'h0, $urandom_range(0, 15) & 32'hF, a, d} , 16, -1);
    end
    check("digits_rand", digits, digits_m);

    // other control registers, no-op and unmapped addresses
    send_frame(32'h09A5, 16, -1);
    send_frame(32'h0F01, 16, -1);
    send_frame(32'h0D55, 16, -1);
    send_frame(32'h0E77, 16, -1);
    send_frame(32'h0012, 16, -1);
    send_frame(32'h0A05, 16, -1);
    check("decode_mode", decode_mode, 8'hA5);
    check("display_test", display_test, 1);
    check("digits_after_noop", digits, digits_m);
    check("intensity_5", intensity, 4'h5);

    // 4: short frame
    send_frame(32'hA5F, 12, -1);
    check("intensity_after_err", intensity, 4'h5);
    check("frame_addr_held", frame_addr, 4'hA);

    // 5: long frame keeps last 16 bits, scan limit truncation
    send_frame(32'hF0A0F, 20, -1);
    check("intensity_F", intensity, 4'hF);
    send_frame(32'h0BFF, 16, -1);
    check("scan_limit", scan_limit, 3'd7);

    // 6: reset mid-frame drops the frame without frame_err
    send_frame(32'h0A0F, 16, 8);
    check_all_zero("midreset");
    send_frame(32'h0A03, 16, -1);
    check("intensity_3", intensity, 4'h3);
    check("digits_after_rst", digits, 64'd0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
